// File: rtl/mem_ctrl_pkg.sv
// rtl/mem_ctrl_pkg.sv - shared encodings for the byte-serial memory controller
package mem_ctrl_pkg;

   typedef enum logic [1:0] {
      MC_IDLE  = 2'd0,
      MC_READ  = 2'd1,
      MC_WRITE = 2'd2,
      MC_DONE  = 2'd3
   } mc_state_t;

   typedef enum logic {
      REQ_MEM = 1'b0,
      REQ_IF  = 1'b1
   } req_t;

   localparam logic [1:0] MASK_BYTE = 2'b01;
   localparam logic [1:0] MASK_HALF = 2'b10;
   localparam logic [1:0] MASK_WORD = 2'b11;

   // Mask 00 falls through to a full word store.
   function automatic logic [2:0] mask_bytes(input logic [1:0] mask);
      case (mask)
         MASK_BYTE: return 3'd1;
         MASK_HALF: return 3'd2;
         default:   return 3'd4;
      endcase
   endfunction

endpackage

// File: rtl/mem_ctrl_arb.sv
// rtl/mem_ctrl_arb.sv - fixed-priority request select: MEM write > MEM read > fetch
module mem_ctrl_arb
   import mem_ctrl_pkg::*;
(
   input  logic w_en_i,
   input  logic r_en_i,
   input  logic if_req_i,
   output logic valid_o,
   output logic write_o,
   output req_t id_o
);

   assign valid_o = w_en_i | r_en_i | if_req_i;
   assign write_o = w_en_i;
   assign id_o    = (w_en_i | r_en_i) ? REQ_MEM : REQ_IF;

endmodule

// File: rtl/mem_ctrl.sv
// rtl/mem_ctrl.sv - byte-serial RAM controller for MEM stage and fetch; MEMCTRL_IO_STALL_EN adds an IO write stall
module mem_ctrl
   import mem_ctrl_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst,
`ifdef MEMCTRL_IO_STALL_EN
   input  logic              io_buffer_full_i,
`endif
   input  logic              ram_r_enable_i,
   input  logic              ram_w_enable_i,
   input  logic [31:0]       ram_addr_i,
   input  logic [31:0]       ram_w_data_i,
   input  logic [1:0]        ram_mask_i,
   output logic [31:0]       ram_r_data_o,
   output logic              ram_done_o,
   output logic              ram_busy_o,
   input  logic              if_req_i,
   input  logic [31:0]       if_addr_i,
   output logic [31:0]       if_data_o,
   output logic              if_done_o,
   input  logic [7:0]        mem_din_i,
   output logic [7:0]        mem_dout_o,
   output logic [ADDR_W-1:0] mem_a_o,
   output logic              mem_wr_o
);

   mc_state_t         state_q;
   req_t              req_q;
   req_t              grant_id;
   logic              grant_valid, grant_write;
   logic [2:0]        cnt_q, nbytes_q, cnt_d;
   logic [ADDR_W-1:0] base_q, addr_d, a_next_d;
   logic [31:0]       wdata_q;
   logic [23:0]       rbuf_q;
   logic              io_full;

   logic [31:0]       ram_r_data_q, if_data_q;
   logic              ram_done_q, if_done_q, ram_busy_q, mem_wr_q;
   logic [7:0]        mem_dout_q;
   logic [ADDR_W-1:0] mem_a_q;

   mem_ctrl_arb u_arb (
      .w_en_i   (ram_w_enable_i),
      .r_en_i   (ram_r_enable_i),
      .if_req_i (if_req_i),
      .valid_o  (grant_valid),
      .write_o  (grant_write),
      .id_o     (grant_id)
   );

`ifdef MEMCTRL_IO_STALL_EN
   assign io_full = io_buffer_full_i;
`else
   assign io_full = 1'b0;
`endif

   assign cnt_d    = cnt_q + 3'd1;
   assign a_next_d = base_q + ADDR_W'(cnt_d);
   assign addr_d   = (grant_id == REQ_IF) ? if_addr_i[ADDR_W-1:0] : ram_addr_i[ADDR_W-1:0];

   // Writes into the IO window back off while the IO buffer is full.
   function automatic logic hold(input logic [ADDR_W-1:0] a);
      return io_full && (a[17:16] == 2'b11);
   endfunction

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= MC_IDLE;
         req_q        <= REQ_MEM;
         cnt_q        <= '0;
         nbytes_q     <= '0;
         base_q       <= '0;
         wdata_q      <= '0;
         rbuf_q       <= '0;
         ram_r_data_q <= '0;
         if_data_q    <= '0;
         ram_done_q   <= 1'b0;
         if_done_q    <= 1'b0;
         ram_busy_q   <= 1'b0;
         mem_wr_q     <= 1'b0;
         mem_dout_q   <= '0;
         mem_a_q      <= '0;
      end else begin
         ram_done_q <= 1'b0;
         if_done_q  <= 1'b0;
         case (state_q)
            MC_IDLE: begin
               if (grant_valid) begin
                  base_q     <= addr_d;
                  req_q      <= grant_id;
                  cnt_q      <= '0;
                  mem_a_q    <= addr_d;
                  ram_busy_q <= 1'b1;
                  if (grant_write) begin
                     state_q    <= MC_WRITE;
                     nbytes_q   <= mask_bytes(ram_mask_i);
                     wdata_q    <= ram_w_data_i;
                     mem_dout_q <= ram_w_data_i[7:0];
                     mem_wr_q   <= !hold(addr_d);
                  end else begin
                     state_q  <= MC_READ;
                     mem_wr_q <= 1'b0;
                  end
               end
            end
            MC_READ: begin
               // Data for the address of cycle c arrives in cycle c+1.
               cnt_q <= cnt_d;
               case (cnt_q)
                  3'd1:    rbuf_q[7:0]   <= mem_din_i;
                  3'd2:    rbuf_q[15:8]  <= mem_din_i;
                  3'd3:    rbuf_q[23:16] <= mem_din_i;
                  default: ;
               endcase
               if (cnt_q < 3'd3) mem_a_q <= a_next_d;
               if (cnt_q == 3'd4) begin
                  state_q <= MC_DONE;
                  if (req_q == REQ_IF) begin
                     if_data_q <= {mem_din_i, rbuf_q};
                     if_done_q <= 1'b1;
                  end else begin
                     ram_r_data_q <= {mem_din_i, rbuf_q};
                     ram_done_q   <= 1'b1;
                  end
               end
            end
            MC_WRITE: begin
               // A low mem_wr_q here means the current byte is still pending.
               if (mem_wr_q) begin
                  if (cnt_d == nbytes_q) begin
                     state_q    <= MC_DONE;
                     mem_wr_q   <= 1'b0;
                     ram_done_q <= 1'b1;
                  end else begin
                     cnt_q      <= cnt_d;
                     mem_a_q    <= a_next_d;
                     mem_dout_q <= wdata_q[{cnt_d[1:0], 3'b000} +: 8];
                     mem_wr_q   <= !hold(a_next_d);
                  end
               end else begin
                  mem_wr_q <= !hold(mem_a_q);
               end
            end
            MC_DONE: begin
               state_q    <= MC_IDLE;
               ram_busy_q <= 1'b0;
            end
            default: state_q <= MC_IDLE;
         endcase
      end
   end

   a_no_dual_req: assert property (@(posedge clk) disable iff (!rst)
      !(ram_w_enable_i && ram_r_enable_i));

   assign ram_r_data_o = ram_r_data_q;
   assign if_data_o    = if_data_q;
   assign ram_done_o   = ram_done_q;
   assign if_done_o    = if_done_q;
   assign ram_busy_o   = ram_busy_q;
   assign mem_wr_o     = mem_wr_q;
   assign mem_dout_o   = mem_dout_q;
   assign mem_a_o      = mem_a_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// tb/tb_mem_ctrl.sv - randomized self-checking bench for mem_ctrl against a byte-array memory model
module tb_mem_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        ram_r_enable_i = 1'b0, ram_w_enable_i = 1'b0, if_req_i = 1'b0;
   logic [31:0] ram_addr_i = '0, ram_w_data_i = '0, if_addr_i = '0;
   logic [1:0]  ram_mask_i = '0;
   logic [31:0] ram_r_data_o, if_data_o;
   logic        ram_done_o, ram_busy_o, if_done_o, mem_wr_o;
   logic [7:0]  mem_din_i = '0, mem_dout_o;
   logic [31:0] mem_a_o;
`ifdef MEMCTRL_IO_STALL_EN
   logic        io_buffer_full_i = 1'b0;
`endif

   int n_chk = 0;
   int n_pass = 0;

   logic [7:0]  ram   [int unsigned];
   logic [7:0]  model [int unsigned];
   logic [39:0] wlog[$];
   logic [31:0] a_seen [8];
   logic [31:0] last_if = '0;

   mem_ctrl #(.ADDR_W(32)) dut (
      .clk(clk), .rst(rst),
`ifdef MEMCTRL_IO_STALL_EN
      .io_buffer_full_i(io_buffer_full_i),
`endif
      .ram_r_enable_i(ram_r_enable_i), .ram_w_enable_i(ram_w_enable_i),
      .ram_addr_i(ram_addr_i), .ram_w_data_i(ram_w_data_i), .ram_mask_i(ram_mask_i),
      .ram_r_data_o(ram_r_data_o), .ram_done_o(ram_done_o), .ram_busy_o(ram_busy_o),
      .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_data_o(if_data_o), .if_done_o(if_done_o),
      .mem_din_i(mem_din_i), .mem_dout_o(mem_dout_o), .mem_a_o(mem_a_o), .mem_wr_o(mem_wr_o)
   );

   always #5 clk = ~clk;

   // External RAM: writes commit at the edge, read data follows the address by one cycle.
   always @(posedge clk) begin
      if (mem_wr_o) begin
         ram[mem_a_o] = mem_dout_o;
         wlog.push_back({mem_a_o, mem_dout_o});
      end
      mem_din_i <= ram.exists(mem_a_o) ? ram[mem_a_o] : 8'h00;
   end

   task automatic poke(input logic [31:0] a, input logic [7:0] d);
      ram[a]   = d;
      model[a] = d;
   endtask

   function automatic logic [31:0] exp_word(input logic [31:0] a);
      logic [31:0] r;
      for (int i = 0; i < 4; i++) r[8*i +: 8] = model.exists(a + 32'(i)) ? model[a + 32'(i)] : 8'h00;
      return r;
   endfunction

   function automatic int size_of(input logic [1:0] m);
      return (m == 2'b01) ? 1 : (m == 2'b10) ? 2 : 4;
   endfunction

   // kind: 0 fetch, 1 load, 2 store; lat is the cycle of the done pulse, 0 on timeout
   task automatic run_op(input int kind, input logic [31:0] addr, input logic [31:0] data,
                         input logic [1:0] mask, output int lat, output logic [31:0] rdata);
      @(negedge clk);
      wlog.delete();
      if (kind == 0) begin if_req_i = 1'b1; if_addr_i = addr; end
      else if (kind == 1) begin ram_r_enable_i = 1'b1; ram_addr_i = addr; end
      else begin ram_w_enable_i = 1'b1; ram_addr_i = addr; ram_w_data_i = data; ram_mask_i = mask; end
      @(posedge clk);
      @(negedge clk);
      if_req_i = 1'b0; ram_r_enable_i = 1'b0; ram_w_enable_i = 1'b0;
      lat = 0;
      rdata = '0;
      for (int k = 1; k <= 20; k++) begin
         if (k < 8) a_seen[k] = mem_a_o;
         if ((kind == 0) ? if_done_o : ram_done_o) begin
            lat = k;
            rdata = (kind == 0) ? if_data_o : ram_r_data_o;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic test_store(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] mask);
      int lat, n;
      logic [31:0] rd;
      n = size_of(mask);
      run_op(2, addr, data, mask, lat, rd);
      for (int i = 0; i < n; i++) model[addr + 32'(i)] = data[8*i +: 8];
      n_chk++;
      if (lat !== n + 1) $display("FAIL store_latency a=%h got %0d exp %0d", addr, lat, n + 1);
      else n_pass++;
      n_chk++;
      if (wlog.size() != n) $display("FAIL store_count a=%h got %0d exp %0d", addr, wlog.size(), n);
      else begin
         n_pass++;
         for (int i = 0; i < n; i++) begin
            n_chk++;
            if (wlog[i] !== {addr + 32'(i), data[8*i +: 8]})
               $display("FAIL store_byte%0d got %h exp %h", i, wlog[i], {addr + 32'(i), data[8*i +: 8]});
            else n_pass++;
         end
      end
   endtask

   task automatic test_load(input int kind, input logic [31:0] addr);
      int lat;
      logic [31:0] rd, exp;
      exp = exp_word(addr);
      run_op(kind, addr, '0, '0, lat, rd);
      if (kind == 0) last_if = exp;
      n_chk++;
      if (lat !== 6) $display("FAIL load_latency k=%0d a=%h got %0d exp 6", kind, addr, lat);
      else n_pass++;
      n_chk++;
      if (rd !== exp) $display("FAIL load_data k=%0d a=%h got %h exp %h", kind, addr, rd, exp);
      else n_pass++;
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      n_chk++;
      if ({ram_r_data_o, if_data_o, mem_dout_o, mem_a_o, mem_wr_o, ram_done_o, if_done_o, ram_busy_o} !== '0)
         $display("FAIL reset_outputs got nonzero busy=%b a=%h", ram_busy_o, mem_a_o);
      else n_pass++;
      rst = 1'b1;
      poke(32'h40, 8'h78); poke(32'h41, 8'h56); poke(32'h42, 8'h34); poke(32'h43, 8'h12);
      @(negedge clk);
      if_req_i = 1'b1; if_addr_i = 32'h40;
      @(posedge clk);
      @(negedge clk);
      if_req_i = 1'b0;
      @(negedge clk);
      n_chk++;
      if (ram_busy_o !== 1'b1 || mem_a_o !== 32'h41) $display("FAIL mid_read got busy=%b a=%h exp 1 00000041", ram_busy_o, mem_a_o);
      else n_pass++;
      #2 rst = 1'b0;
      #1;
      n_chk++;
      if ({ram_r_data_o, if_data_o, mem_dout_o, mem_a_o, mem_wr_o, ram_done_o, if_done_o, ram_busy_o} !== '0)
         $display("FAIL reset_abort got busy=%b a=%h ifd=%h", ram_busy_o, mem_a_o, if_done_o);
      else n_pass++;
      @(negedge clk);
      rst = 1'b1;
      test_load(0, 32'h40);
   endtask

   task automatic test_fetch();
      poke(32'h100, 8'h13); poke(32'h101, 8'h00); poke(32'h102, 8'h00); poke(32'h103, 8'h93);
      test_load(0, 32'h100);
      n_chk++;
      if ({a_seen[1], a_seen[2], a_seen[3], a_seen[4]} !== {32'h100, 32'h101, 32'h102, 32'h103})
         $display("FAIL fetch_addr_seq got %h %h %h %h exp 100..103", a_seen[1], a_seen[2], a_seen[3], a_seen[4]);
      else n_pass++;
      n_chk++;
      if (if_data_o !== 32'h9300_0013) $display("FAIL fetch_word got %h exp 93000013", if_data_o);
      else n_pass++;
   endtask

   task automatic test_sw_lw();
      test_store(32'h205, 32'hABAB_ABAB, 2'b01);
      test_store(32'h300, 32'h1122_3344, 2'b11);
      test_load(1, 32'h300);
      n_chk++;
      if (ram_r_data_o !== 32'h1122_3344) $display("FAIL lw_back got %h exp 11223344", ram_r_data_o);
      else n_pass++;
      n_chk++;
      if (if_data_o !== last_if) $display("FAIL if_data_hold got %h exp %h", if_data_o, last_if);
      else n_pass++;
      test_store(32'hFFFF_FFFE, 32'hCAFE_F00D, 2'b11);
      test_load(1, 32'hFFFF_FFFC);
      test_load(0, 32'h0);
   endtask

   task automatic test_priority(input bit mem_write);
      int rd_c, if_c;
      logic [31:0] rd_v, if_v, exp_m, exp_f;
      @(negedge clk);
      if (mem_write) begin
         ram_w_enable_i = 1'b1; ram_addr_i = 32'h602; ram_w_data_i = 32'h0000_00EE; ram_mask_i = 2'b01;
         model[32'h602] = 8'hEE;
      end else begin
         ram_r_enable_i = 1'b1; ram_addr_i = 32'h500;
      end
      exp_m = exp_word(32'h500);
      exp_f = exp_word(32'h600);
      if_req_i = 1'b1; if_addr_i = 32'h600;
      @(posedge clk);
      @(negedge clk);
      ram_r_enable_i = 1'b0; ram_w_enable_i = 1'b0;
      rd_c = 0; if_c = 0; rd_v = '0; if_v = '0;
      for (int k = 1; k <= 16; k++) begin
         if (ram_done_o && rd_c == 0) begin rd_c = k; rd_v = ram_r_data_o; end
         if (if_done_o && if_c == 0) begin if_c = k; if_v = if_data_o; end
         if (k == (mem_write ? 4 : 8)) if_req_i = 1'b0;
         @(negedge clk);
      end
      last_if = exp_f;
      n_chk++;
      if (rd_c !== (mem_write ? 2 : 6)) $display("FAIL prio_mem_cycle w=%0d got %0d exp %0d", mem_write, rd_c, mem_write ? 2 : 6);
      else n_pass++;
      n_chk++;
      if (if_c !== (mem_write ? 9 : 13)) $display("FAIL prio_if_cycle w=%0d got %0d exp %0d", mem_write, if_c, mem_write ? 9 : 13);
      else n_pass++;
      n_chk++;
      if (if_v !== exp_f || (!mem_write && rd_v !== exp_m))
         $display("FAIL prio_data w=%0d got %h/%h exp %h/%h", mem_write, rd_v, if_v, exp_m, exp_f);
      else n_pass++;
      n_chk++;
      if (ram_busy_o !== 1'b0) $display("FAIL prio_idle_after got busy=%b exp 0", ram_busy_o);
      else n_pass++;
   endtask

   task automatic test_random();
      for (int i = 0; i < 32; i++) begin
         poke(32'h400 + 32'(i), 8'($urandom));
         poke(32'h500 + 32'(i), 8'($urandom));
         poke(32'h600 + 32'(i), 8'($urandom));
      end
      for (int i = 0; i < 24; i++) begin
         case ($urandom_range(0, 2))
            0: test_load(0, 32'h400 + 32'(4 * $urandom_range(0, 7)));
            1: test_load(1, 32'h400 + 32'(4 * $urandom_range(0, 7)));
            default: test_store(32'h400 + 32'($urandom_range(0, 28)), $urandom, 2'($urandom_range(0, 3)));
         endcase
      end
   endtask

`ifdef MEMCTRL_IO_STALL_EN
   task automatic test_stall();
      int wr_seen;
      @(negedge clk);
      wlog.delete();
      io_buffer_full_i = 1'b1;
      ram_w_enable_i = 1'b1; ram_addr_i = 32'h3_0000; ram_w_data_i = 32'h0000_005A; ram_mask_i = 2'b01;
      model[32'h3_0000] = 8'h5A;
      @(posedge clk);
      @(negedge clk);
      ram_w_enable_i = 1'b0;
      wr_seen = 0;
      for (int k = 1; k <= 3; k++) begin
         if (mem_wr_o) wr_seen++;
         if (k == 3) io_buffer_full_i = 1'b0;
         @(negedge clk);
      end
      n_chk++;
      if (wr_seen !== 0) $display("FAIL stall_no_write got %0d writes exp 0", wr_seen);
      else n_pass++;
      n_chk++;
      if (mem_wr_o !== 1'b1 || mem_a_o !== 32'h3_0000 || mem_dout_o !== 8'h5A)
         $display("FAIL stall_resume got wr=%b a=%h d=%h exp 1 00030000 5a", mem_wr_o, mem_a_o, mem_dout_o);
      else n_pass++;
      @(negedge clk);
      n_chk++;
      if (ram_done_o !== 1'b1 || wlog.size() != 1) $display("FAIL stall_done got done=%b writes=%0d exp 1 1", ram_done_o, wlog.size());
      else n_pass++;
   endtask
`endif

   initial begin
      test_reset();
      test_fetch();
      test_sw_lw();
      test_random();
      test_priority(1'b0);
      test_priority(1'b1);
`ifdef MEMCTRL_IO_STALL_EN
      test_stall();
`endif
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
